serial_add_sub: RTL
===================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial adder/subtractor: accepts two WIDTH-bit operands and an op select, then
//  computes A+B or A-B one bit per cycle, LSB first, through a single full_adder and a
//  carry flip-flop. It is the area-lean arithmetic companion to the parallel datapath,
//  used where latency is cheap and gates are not. Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=1)
// PORTS
//  clk        in   1      rising-edge clock; only clock
//  rst_n      in   1      reset, asynchronous, active-low
//  in_valid   in   1      operands + op presented
//  in_ready   out  1      block can accept (high only in IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: A+B, 1: A-B (A + ~B + 1)
//  out_valid  out  1      result/flags valid, held until taken
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  sum/difference, modulo 2^WIDTH
//  cout       out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow   out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, cout=0,
//   overflow=0, shift regs, carry FF and bit counter = 0. Takes effect mid-op; transaction lost.
//  FSM states: IDLE, RUN, HOLD.
//   IDLE: in_ready=1. Edge with in_valid=1 -> latch a, b^{WIDTH{sub}}, carry=sub,
//     cnt=0 -> RUN. Otherwise stay.
//   RUN: in_ready=0. Each edge: full_adder(a_sh[0], b_sh[0], carry) -> shift sum bit
//     in at result MSB (result shifts right), carry<=fa cout, a_sh/b_sh shift right, cnt++.
//     On edge where cnt==WIDTH-1: cout<=fa cout, overflow<=carry XOR fa cout, -> HOLD.
//   HOLD: out_valid=1; result/cout/overflow stable. Edge with out_ready=1 -> IDLE.
//  Latency: out_valid rises exactly WIDTH cycles after the accepting edge; minimum
//   turnaround WIDTH+2 cycles per op (accept, WIDTH RUN edges, take).
//  in_valid while in_ready=0 ignored; operands need not be held after accept.
//  out_ready while out_valid=0 ignored. out_ready may already be high when out_valid
//   rises: take occurs on the next edge.
//  No same-cycle accept-and-take: in_ready returns high in the cycle after the take.
//  WIDTH=1: single RUN cycle; overflow = carry-in XOR cout.
//  result/flags hold their last values in IDLE; only out_valid qualifies them.
//  sub sampled only at accept; changes afterwards have no effect.
// STRUCTURE
//  Shared include serial_alu_defs.vh: state encodings ST_IDLE/ST_RUN/ST_HOLD (2-bit)
//   and OP_ADD=0/OP_SUB=1.
//  One sub-module: the existing full_adder (a, b, c -> s, cout), instantiated once.
//  Counter width $clog2(WIDTH)+1; everything else in this module.
// TESTING (WIDTH=8)
//  1. add 8'h35+8'h4A -> result 8'h7F, cout 0, overflow 0; out_valid exactly 8 cycles
//     after the accept edge.
//  2. add 8'hFF+8'h01 -> 8'h00, cout 1, overflow 0; add 8'h7F+8'h01 -> 8'h80, cout 0,
//     overflow 1.
//  3. sub 8'h80-8'h01 -> 8'h7F, cout 1, overflow 1; sub 8'h05-8'h07 -> 8'hFE, cout 0,
//     overflow 0.
//  4. Backpressure: out_ready=0 for 5 cycles in HOLD -> result/flags stable, in_ready 0;
//     new in_valid with a=8'h11 ignored; after take, in_ready=1 the next cycle.
//  5. rst_n low after 3 RUN cycles -> all outputs at reset values immediately; after
//     release, 8'h10+8'h20 -> 8'h30, no corruption.
//  6. Back-to-back: 8 random add/sub ops, out_ready tied 1 -> each result matches
//     (a±b) mod 256 with correct cout/overflow; 10 cycles per op.

Source files
------------

// File: rtl/serial_add_sub_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_sub_pkg
//   Shared definitions for the bit-serial adder/subtractor:
//     state_t        - FSM state encodings (ST_IDLE / ST_RUN / ST_HOLD, 2-bit)
//     OP_ADD/OP_SUB  - values of the 'sub' op-select input
//     cnt_width()    - width of the serial bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One extra bit over $clog2 keeps WIDTH=1 (where $clog2 is 0) legal.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder; the only arithmetic cell of the serial datapath.
//   Ports:
//     a, b  in  1  addend bits
//     c     in  1  carry in
//     s     out 1  sum bit
//     cout  out 1  carry out
// ----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_sub.sv
// ----------------------------------------------------------------------------
// serial_add_sub
//   Bit-serial adder/subtractor. Operands are latched on an accepting edge and
//   processed LSB first through one full adder and a carry flip-flop, one bit
//   per clock. Subtraction is A + ~B + 1: B is inverted at accept and the carry
//   flip-flop is preloaded with 1.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     in_valid   in   1      operands and op presented
//     in_ready   out  1      high only in IDLE
//     a, b       in   WIDTH  operands
//     sub        in   1      0: A+B, 1: A-B
//     out_valid  out  1      result and flags valid, held until taken
//     out_ready  in   1      consumer takes result
//     result     out  WIDTH  sum / difference modulo 2^WIDTH
//     cout       out  1      carry out of MSB (for subtract: 1 = no borrow)
//     overflow   out  1      signed overflow (carry into MSB ^ carry out)
// ----------------------------------------------------------------------------
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;
  logic             op_is_sub;
  logic [WIDTH:0]   res_cat;

  // Single shared full adder: bit 0 of each shift register plus the carry.
  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c    (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign op_is_sub = (sub == OP_SUB);
  assign accept    = (state_q == ST_IDLE) && in_valid;
  assign last_bit  = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

  // New sum bit enters at the MSB while the register shifts right; after
  // WIDTH shifts bit 0 of the sum has reached result[0]. Concatenating first
  // keeps the slice legal for WIDTH=1.
  assign res_cat = {fa_s, res_sh_q};

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM next state and handshake outputs ----
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == LAST_CNT) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        // Take returns to IDLE; in_ready is therefore high only from the
        // following cycle, so accept and take never share an edge.
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---- Serial datapath ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= a;
      b_sh_q  <= b ^ {WIDTH{op_is_sub}};
      carry_q <= op_is_sub;
      cnt_q   <= '0;
    end else if (state_q == ST_RUN) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_cat[WIDTH:1];
      carry_q  <= fa_cout;
      cnt_q    <= cnt_q + 1'b1;
      if (last_bit) begin
        // carry_q here is the carry into the MSB.
        cout_q <= fa_cout;
        ovf_q  <= carry_q ^ fa_cout;
      end
    end
  end

  assign result   = res_sh_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
